// File: rtl/life_pkg.sv
// Shared types, defaults and the Conway B3/S23 rule for the Game of Life stepper.
package life_pkg;

  localparam int LIFE_ROWS = 16;
  localparam int LIFE_COLS = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_COMMIT  = 2'd2
  } life_state_e;

  typedef logic [LIFE_COLS-1:0] row_t;

  localparam logic [3:0] BIRTH      = 4'd3;
  localparam logic [3:0] SURVIVE_LO = 4'd2;
  localparam logic [3:0] SURVIVE_HI = 4'd3;

  function automatic logic next_cell(input logic alive, input logic [3:0] cnt);
    logic res;
    if (alive) begin
      res = (cnt >= SURVIVE_LO) && (cnt <= SURVIVE_HI);
    end else begin
      res = (cnt == BIRTH);
    end
    return res;
  endfunction

endpackage

// File: rtl/life_row_next.sv
// Combinational next-state of one board row from the rows above, at and below it.
module life_row_next
  import life_pkg::*;
#(
  parameter int COLS = LIFE_COLS
) (
  input  logic [COLS-1:0] i_above,
  input  logic [COLS-1:0] i_cur,
  input  logic [COLS-1:0] i_below,
  output logic [COLS-1:0] o_next
);

  // Zero padding on both sides makes off-board columns read as dead.
  logic [COLS+1:0] w_above_ext;
  logic [COLS+1:0] w_cur_ext;
  logic [COLS+1:0] w_below_ext;
  logic [3:0]      w_cnt;

  // Per-cell neighbour count and rule application
  always_comb begin
    w_above_ext = {1'b0, i_above, 1'b0};
    w_cur_ext   = {1'b0, i_cur, 1'b0};
    w_below_ext = {1'b0, i_below, 1'b0};
    w_cnt       = 4'd0;
    o_next      = '0;
    for (int c = 0; c < COLS; c++) begin
      w_cnt = {3'b000, w_above_ext[c]} + {3'b000, w_above_ext[c+1]} + {3'b000, w_above_ext[c+2]}
            + {3'b000, w_cur_ext[c]}                                 + {3'b000, w_cur_ext[c+2]}
            + {3'b000, w_below_ext[c]} + {3'b000, w_below_ext[c+1]} + {3'b000, w_below_ext[c+2]};
      o_next[c] = next_cell(i_cur[c], w_cnt);
    end
  end

endmodule

// File: rtl/life_generation_stepper.sv
// Advances the Life board one generation per accepted trigger: one row per cycle
// into a shadow buffer, then an atomic commit to the visible board.
module life_generation_stepper
  import life_pkg::*;
#(
  parameter int ROWS  = LIFE_ROWS,
  parameter int COLS  = LIFE_COLS,
  parameter int GEN_W = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    tick,
  input  logic                    run,
  input  logic                    step,
  input  logic                    clear,
  input  logic                    load_en,
  input  logic [$clog2(ROWS)-1:0] load_row,
  input  logic [COLS-1:0]         load_data,
  output logic [ROWS*COLS-1:0]    board,
  output logic                    busy,
  output logic                    gen_done,
  output logic [GEN_W-1:0]        generation,
  output logic [7:0]              missed_ticks
);

  localparam int RW = $clog2(ROWS);

  localparam logic [1:0] S_IDLE    = ST_IDLE;
  localparam logic [1:0] S_COMPUTE = ST_COMPUTE;
  localparam logic [1:0] S_COMMIT  = ST_COMMIT;

  localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);

  logic [1:0]           r_state;
  logic [RW-1:0]        r_row_idx;
  logic [ROWS*COLS-1:0] r_board;
  logic [ROWS*COLS-1:0] r_shadow;
  logic [GEN_W-1:0]     r_gen;
  logic [7:0]           r_missed;
  logic                 r_gen_done;
  logic                 r_busy;

  logic                 w_tick_run;
  logic                 w_trigger;
  logic                 w_load_ok;
  logic [7:0]           w_missed_inc;
  logic [COLS-1:0]      w_above;
  logic [COLS-1:0]      w_cur;
  logic [COLS-1:0]      w_below;
  logic [COLS-1:0]      w_next;

  assign w_tick_run   = tick & run;
  assign w_trigger    = w_tick_run | (step & ~run);
  assign w_load_ok    = (int'(load_row) < ROWS);
  assign w_missed_inc = (r_missed == 8'hFF) ? 8'hFF : (r_missed + 8'd1);

  // Neighbour rows always come from the committed board; edges read as dead
  always_comb begin
    w_cur = r_board[int'(r_row_idx)*COLS +: COLS];
    if (r_row_idx == '0) begin
      w_above = '0;
    end else begin
      w_above = r_board[(int'(r_row_idx) - 1)*COLS +: COLS];
    end
    if (r_row_idx == LAST_ROW) begin
      w_below = '0;
    end else begin
      w_below = r_board[(int'(r_row_idx) + 1)*COLS +: COLS];
    end
  end

  life_row_next #(
    .COLS(COLS)
  ) u_row_next (
    .i_above(w_above),
    .i_cur  (w_cur),
    .i_below(w_below),
    .o_next (w_next)
  );

  // Sequencer: reset > clear > load > trigger
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_row_idx  <= '0;
      r_board    <= '0;
      r_shadow   <= '0;
      r_gen      <= '0;
      r_missed   <= 8'd0;
      r_gen_done <= 1'b0;
      r_busy     <= 1'b0;
    end else if (clear) begin
      r_state    <= S_IDLE;
      r_row_idx  <= '0;
      r_board    <= '0;
      r_gen      <= '0;
      r_gen_done <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_gen_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (load_en) begin
            if (w_load_ok) begin
              r_board[int'(load_row)*COLS +: COLS] <= load_data;
            end
            if (w_tick_run) begin
              r_missed <= w_missed_inc;
            end
          end else if (w_trigger) begin
            r_state   <= S_COMPUTE;
            r_row_idx <= '0;
            r_busy    <= 1'b1;
          end
        end
        S_COMPUTE: begin
          r_shadow[int'(r_row_idx)*COLS +: COLS] <= w_next;
          if (r_row_idx == LAST_ROW) begin
            r_state   <= S_COMMIT;
            r_row_idx <= '0;
          end else begin
            r_row_idx <= r_row_idx + 1'b1;
          end
          if (w_tick_run) begin
            r_missed <= w_missed_inc;
          end
        end
        S_COMMIT: begin
          r_board    <= r_shadow;
          r_gen      <= r_gen + 1'b1;
          r_gen_done <= 1'b1;
          r_state    <= S_IDLE;
          r_busy     <= 1'b0;
          if (w_tick_run) begin
            r_missed <= w_missed_inc;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_row_idx <= '0;
          r_busy    <= 1'b0;
        end
      endcase
    end
  end

  assign board        = r_board;
  assign busy         = r_busy;
  assign gen_done     = r_gen_done;
  assign generation   = r_gen;
  assign missed_ticks = r_missed;

endmodule

// File: tb/tb_life_generation_stepper.sv
// Self-checking bench: pattern table plus scoreboard of expected generations.
module tb_life_generation_stepper;

  localparam int ROWS  = 16;
  localparam int COLS  = 16;
  localparam int GEN_W = 16;
  localparam int BW    = ROWS * COLS;

  logic                    clk;
  logic                    reset;
  logic                    tick;
  logic                    run;
  logic                    step;
  logic                    clear;
  logic                    load_en;
  logic [$clog2(ROWS)-1:0] load_row;
  logic [COLS-1:0]         load_data;
  logic [BW-1:0]           board;
  logic                    busy;
  logic                    gen_done;
  logic [GEN_W-1:0]        generation;
  logic [7:0]              missed_ticks;

  life_generation_stepper #(.ROWS(ROWS), .COLS(COLS), .GEN_W(GEN_W)) dut (
    .clk(clk), .reset(reset), .tick(tick), .run(run), .step(step), .clear(clear),
    .load_en(load_en), .load_row(load_row), .load_data(load_data), .board(board),
    .busy(busy), .gen_done(gen_done), .generation(generation), .missed_ticks(missed_ticks)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [BW-1:0] init;
    int            ngen;
    logic [BW-1:0] expb;
  } vec_t;

  vec_t             vecs[6];
  int               checks = 0;
  int               errors = 0;
  logic [BW-1:0]    m_board;
  logic [GEN_W-1:0] m_gen;
  logic [BW-1:0]    q_board[$];
  logic [GEN_W-1:0] q_gen[$];

  task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [BW-1:0] set_row(input logic [BW-1:0] b, input int r, input logic [COLS-1:0] v);
    logic [BW-1:0] t;
    t = b;
    t[r*COLS +: COLS] = v;
    return t;
  endfunction

  // Independent reference: explicit bounds checks on every neighbour
  function automatic logic [BW-1:0] model_next(input logic [BW-1:0] b);
    logic [BW-1:0] n;
    int cnt, rr, cc;
    n = '0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        cnt = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            rr = r + dr;
            cc = c + dc;
            if (!(dr == 0 && dc == 0) && rr >= 0 && rr < ROWS && cc >= 0 && cc < COLS) begin
              if (b[rr*COLS + cc]) cnt++;
            end
          end
        end
        if (b[r*COLS + c]) n[r*COLS + c] = (cnt == 2 || cnt == 3);
        else               n[r*COLS + c] = (cnt == 3);
      end
    end
    return n;
  endfunction

  task automatic load_board(input logic [BW-1:0] b);
    for (int r = 0; r < ROWS; r++) begin
      @(negedge clk);
      load_en   = 1'b1;
      load_row  = r[$clog2(ROWS)-1:0];
      load_data = b[r*COLS +: COLS];
    end
    @(negedge clk);
    load_en = 1'b0;
    m_board = b;
  endtask

  task automatic push_expect();
    m_board = model_next(m_board);
    m_gen   = m_gen + 1'b1;
    q_board.push_back(m_board);
    q_gen.push_back(m_gen);
  endtask

  // Wait for gen_done starting from cycle n, then pop and compare
  task automatic wait_done(input int n_start);
    int n;
    logic seen;
    logic [BW-1:0] eb;
    logic [GEN_W-1:0] eg;
    n = n_start;
    seen = 1'b0;
    while (n < ROWS + 10) begin
      if (gen_done) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
      n++;
    end
    chk("gen_done_seen", BW'(seen), BW'(1));
    chk("latency", BW'(n), BW'(ROWS + 2));
    eb = (q_board.size() > 0) ? q_board.pop_front() : '0;
    eg = (q_gen.size() > 0) ? q_gen.pop_front() : '0;
    chk("sb_board", board, eb);
    chk("sb_generation", BW'(generation), BW'(eg));
    chk("busy_at_done", BW'(busy), BW'(0));
    @(negedge clk);
    chk("gen_done_single", BW'(gen_done), BW'(0));
  endtask

  task automatic run_gen(input logic use_step);
    push_expect();
    @(negedge clk);
    if (use_step) step = 1'b1;
    else          tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    step = 1'b0;
    chk("busy_start", BW'(busy), BW'(1));
    wait_done(1);
  endtask

  task automatic watch_idle(input string name, input int cycles);
    logic any;
    any = 1'b0;
    repeat (cycles) begin
      @(negedge clk);
      if (gen_done || busy) any = 1'b1;
    end
    chk(name, BW'(any), BW'(0));
  endtask

  initial begin
    logic [BW-1:0] b;
    reset = 1'b1; tick = 1'b0; run = 1'b0; step = 1'b0; clear = 1'b0;
    load_en = 1'b0; load_row = '0; load_data = '0;
    m_board = '0; m_gen = '0;

    b = set_row('0, 7, 16'h0380);
    vecs[0] = '{init: b, ngen: 1,
                expb: set_row(set_row(set_row('0, 6, 16'h0100), 7, 16'h0100), 8, 16'h0100)};
    vecs[1] = '{init: b, ngen: 2, expb: b};
    b = set_row(set_row('0, 0, 16'h0003), 1, 16'h0003);
    vecs[2] = '{init: b, ngen: 3, expb: b};
    vecs[3] = '{init: set_row('0, 0, 16'h8000), ngen: 1, expb: '0};
    vecs[4] = '{init: set_row('0, 0, 16'h0007), ngen: 1,
                expb: set_row(set_row('0, 0, 16'h0002), 1, 16'h0002)};
    vecs[5] = '{init: set_row(set_row(set_row('0, 4, 16'h8000), 5, 16'h8000), 6, 16'h8000), ngen: 1,
                expb: set_row('0, 5, 16'hC000)};

    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_board", board, '0);
    chk("rst_generation", BW'(generation), BW'(0));
    chk("rst_busy", BW'(busy), BW'(0));
    chk("rst_gen_done", BW'(gen_done), BW'(0));
    chk("rst_missed", BW'(missed_ticks), BW'(0));

    for (int i = 0; i < 6; i++) begin
      @(negedge clk); clear = 1'b1;
      @(negedge clk); clear = 1'b0;
      chk("clear_board", board, '0);
      m_board = '0; m_gen = '0;
      load_board(vecs[i].init);
      chk("loaded_board", board, vecs[i].init);
      run = 1'b1;
      for (int g = 0; g < vecs[i].ngen; g++) run_gen(1'b0);
      chk($sformatf("vec%0d_final", i), board, vecs[i].expb);
    end

    // Overrun: second tick 5 cycles into COMPUTE is dropped; load while busy ignored
    @(negedge clk); clear = 1'b1;
    @(negedge clk); clear = 1'b0;
    m_gen = '0;
    load_board(set_row('0, 7, 16'h0380));
    run = 1'b1;
    push_expect();
    @(negedge clk); tick = 1'b1;
    @(negedge clk); tick = 1'b0;
    repeat (4) @(negedge clk);
    tick = 1'b1;
    @(negedge clk); tick = 1'b0;
    load_en = 1'b1; load_row = 4'd3; load_data = 16'hFFFF;
    @(negedge clk); load_en = 1'b0;
    wait_done(7);
    chk("overrun_missed", BW'(missed_ticks), BW'(1));

    // Paused: tick ignored, step advances, step with run=1 ignored
    run = 1'b0;
    @(negedge clk); tick = 1'b1;
    @(negedge clk); tick = 1'b0;
    watch_idle("paused_tick_idle", ROWS + 4);
    chk("paused_tick_board", board, m_board);
    chk("paused_tick_gen", BW'(generation), BW'(m_gen));
    run_gen(1'b1);
    run = 1'b1;
    @(negedge clk); step = 1'b1;
    @(negedge clk); step = 1'b0;
    watch_idle("run_step_idle", ROWS + 4);
    chk("run_step_gen", BW'(generation), BW'(m_gen));

    // Load wins over step (not counted) and over tick (counted)
    run = 1'b0;
    @(negedge clk); load_en = 1'b1; step = 1'b1; load_row = 4'd0; load_data = 16'h00F0;
    @(negedge clk); load_en = 1'b0; step = 1'b0;
    m_board = set_row(m_board, 0, 16'h00F0);
    chk("load_step_busy", BW'(busy), BW'(0));
    chk("load_step_board", board, m_board);
    watch_idle("load_step_idle", ROWS + 4);
    chk("load_step_gen", BW'(generation), BW'(m_gen));
    chk("load_step_missed", BW'(missed_ticks), BW'(1));
    run = 1'b1;
    @(negedge clk); load_en = 1'b1; tick = 1'b1; load_row = 4'd1; load_data = 16'h0F00;
    @(negedge clk); load_en = 1'b0; tick = 1'b0;
    m_board = set_row(m_board, 1, 16'h0F00);
    chk("load_tick_board", board, m_board);
    chk("load_tick_missed", BW'(missed_ticks), BW'(2));
    watch_idle("load_tick_idle", ROWS + 4);

    // Clear at cycle 5 of COMPUTE aborts; missed_ticks kept
    @(negedge clk); tick = 1'b1;
    @(negedge clk); tick = 1'b0;
    repeat (4) @(negedge clk);
    clear = 1'b1;
    @(negedge clk); clear = 1'b0;
    chk("clr_board", board, '0);
    chk("clr_gen", BW'(generation), BW'(0));
    chk("clr_busy", BW'(busy), BW'(0));
    chk("clr_gen_done", BW'(gen_done), BW'(0));
    chk("clr_missed", BW'(missed_ticks), BW'(2));
    watch_idle("clr_no_commit", ROWS + 4);
    chk("clr_board_after", board, '0);

    // Reset mid-compute clears everything including missed_ticks
    load_board(set_row('0, 7, 16'h0380));
    @(negedge clk); tick = 1'b1;
    @(negedge clk); tick = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    chk("rst2_board", board, '0);
    chk("rst2_gen", BW'(generation), BW'(0));
    chk("rst2_busy", BW'(busy), BW'(0));
    chk("rst2_gen_done", BW'(gen_done), BW'(0));
    chk("rst2_missed", BW'(missed_ticks), BW'(0));
    watch_idle("rst2_no_commit", ROWS + 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
